json_root_scanner: RTL

JSON_ROOT_SCANNER -- requirements
Module: json_root_scanner

---
 rtl/json_root_scanner.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/json_root_scanner.sv
// json_root_scanner: byte-serial scanner that classifies the single root
// value of a JSON text (literal, number or string), measures its token
// length and reports one result per text with a valid/ready handshake.
module json_root_scanner (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [2:0]  out_status,
   output logic [2:0]  out_type,
   output logic [15:0] out_len
);

   typedef enum logic [3:0] {
      WS_LEAD, LIT, NUM, STR, STR_ESC, STR_HEX, WS_TRAIL, DRAIN, REPORT
   } state_t;

   // Number grammar positions; ZERO, INT, FRAC and EXP_DIG are accepting.
   typedef enum logic [2:0] {
      N_SIGN, N_ZERO, N_INT, N_DOT, N_FRAC, N_EXP, N_EXP_SIGN, N_EXP_DIG
   } num_t;

   localparam logic [2:0] ST_OK      = 3'd0;
   localparam logic [2:0] ST_INVALID = 3'd1;
   localparam logic [2:0] ST_MISS_Q  = 3'd2;
   localparam logic [2:0] ST_NOT_SNG = 3'd3;
   localparam logic [2:0] ST_NO_VAL  = 3'd4;

   localparam logic [2:0] TY_NONE   = 3'd0;
   localparam logic [2:0] TY_NUMBER = 3'd4;
   localparam logic [2:0] TY_STRING = 3'd5;

   // Literal kinds: 0 null, 1 true, 2 false.
   function automatic logic [7:0] f_lit_char(input logic [1:0] kind, input logic [2:0] idx);
      logic [7:0] c;
      c = 8'h00;
      case ({kind, idx})
         {2'd0, 3'd1}: c = "u";
         {2'd0, 3'd2}: c = "l";
         {2'd0, 3'd3}: c = "l";
         {2'd1, 3'd1}: c = "r";
         {2'd1, 3'd2}: c = "u";
         {2'd1, 3'd3}: c = "e";
         {2'd2, 3'd1}: c = "a";
         {2'd2, 3'd2}: c = "l";
         {2'd2, 3'd3}: c = "s";
         {2'd2, 3'd4}: c = "e";
         default:      c = 8'h00;
      endcase
      return c;
   endfunction

   state_t      r_state, w_next_state, w_byte_state;
   num_t        r_num_sub, w_num_sub_n;
   logic [1:0]  r_lit_kind, w_lit_kind_n;
   logic [2:0]  r_lit_idx, w_lit_idx_n;
   logic [1:0]  r_hex_cnt, w_hex_cnt_n;
   logic [2:0]  r_err, w_byte_err;
   logic [2:0]  r_type, w_byte_type;
   logic [15:0] r_len, w_len_n;
   logic [2:0]  r_out_status, r_out_type, w_fin_status, w_fin_type;
   logic [15:0] r_out_len;
   logic        w_count, w_accept;
   logic        w_is_ws, w_is_digit, w_is_hex, w_is_exp, w_num_acc;

   assign w_is_ws    = (in_data == 8'h20) || (in_data == 8'h09) ||
                       (in_data == 8'h0A) || (in_data == 8'h0D);
   assign w_is_digit = (in_data >= "0") && (in_data <= "9");
   assign w_is_hex   = w_is_digit || ((in_data >= "a") && (in_data <= "f")) ||
                       ((in_data >= "A") && (in_data <= "F"));
   assign w_is_exp   = (in_data == "e") || (in_data == "E");
   assign w_num_acc  = (w_num_sub_n == N_ZERO) || (w_num_sub_n == N_INT) ||
                       (w_num_sub_n == N_FRAC) || (w_num_sub_n == N_EXP_DIG);
   assign w_accept   = in_valid && in_ready;
   assign w_len_n    = (w_count && (r_len != 16'hFFFF)) ? r_len + 16'd1 : r_len;

   // Effect of the current input byte on the scan state, ignoring in_last.
   always_comb begin
      // NOTE: every comb output gets a default first so no path infers a latch.
      w_byte_state = r_state;
      w_byte_err   = ST_OK;
      w_byte_type  = r_type;
      w_count      = 1'b0;
      w_lit_kind_n = r_lit_kind;
      w_lit_idx_n  = r_lit_idx;
      w_num_sub_n  = r_num_sub;
      w_hex_cnt_n  = r_hex_cnt;
      case (r_state)
         WS_LEAD: begin
            w_count = 1'b1;
            if (w_is_ws) w_count = 1'b0;
            else if (in_data == "n") begin w_byte_state = LIT; w_lit_kind_n = 2'd0; w_lit_idx_n = 3'd1; end
            else if (in_data == "t") begin w_byte_state = LIT; w_lit_kind_n = 2'd1; w_lit_idx_n = 3'd1; end
            else if (in_data == "f") begin w_byte_state = LIT; w_lit_kind_n = 2'd2; w_lit_idx_n = 3'd1; end
            else if (in_data == "-") begin w_byte_state = NUM; w_num_sub_n = N_SIGN; end
            else if (in_data == "0") begin w_byte_state = NUM; w_num_sub_n = N_ZERO; end
            else if (w_is_digit)     begin w_byte_state = NUM; w_num_sub_n = N_INT; end
            else if (in_data == "\"") w_byte_state = STR;
            else begin w_byte_err = ST_INVALID; w_count = 1'b0; end
         end
         LIT: begin
            if (in_data == f_lit_char(r_lit_kind, r_lit_idx)) begin
               w_count     = 1'b1;
               w_lit_idx_n = r_lit_idx + 3'd1;
               if (r_lit_idx == ((r_lit_kind == 2'd2) ? 3'd4 : 3'd3)) begin
                  w_byte_state = WS_TRAIL;
                  w_byte_type  = (r_lit_kind == 2'd0) ? 3'd1 : (r_lit_kind == 2'd1) ? 3'd3 : 3'd2;
               end
            end else w_byte_err = ST_INVALID;
         end
         NUM: begin
            w_count = 1'b1;
            case (r_num_sub)
               N_SIGN:     if (in_data == "0") w_num_sub_n = N_ZERO;
                           else if (w_is_digit) w_num_sub_n = N_INT;
                           else w_count = 1'b0;
               N_ZERO:     if (in_data == ".") w_num_sub_n = N_DOT;
                           else if (w_is_exp) w_num_sub_n = N_EXP;
                           else w_count = 1'b0;
               N_INT:      if (w_is_digit) w_num_sub_n = N_INT;
                           else if (in_data == ".") w_num_sub_n = N_DOT;
                           else if (w_is_exp) w_num_sub_n = N_EXP;
                           else w_count = 1'b0;
               N_DOT:      if (w_is_digit) w_num_sub_n = N_FRAC; else w_count = 1'b0;
               N_FRAC:     if (w_is_digit) w_num_sub_n = N_FRAC;
                           else if (w_is_exp) w_num_sub_n = N_EXP;
                           else w_count = 1'b0;
               N_EXP:      if ((in_data == "+") || (in_data == "-")) w_num_sub_n = N_EXP_SIGN;
                           else if (w_is_digit) w_num_sub_n = N_EXP_DIG;
                           else w_count = 1'b0;
               N_EXP_SIGN: if (w_is_digit) w_num_sub_n = N_EXP_DIG; else w_count = 1'b0;
               default:    if (w_is_digit) w_num_sub_n = N_EXP_DIG; else w_count = 1'b0;
            endcase
            // A byte that cannot extend the number is re-read as trailing text.
            if (!w_count) begin
               if (!w_num_acc) w_byte_err = ST_INVALID;
               else begin
                  w_byte_type = TY_NUMBER;
                  if (w_is_ws) w_byte_state = WS_TRAIL;
                  else w_byte_err = ST_NOT_SNG;
               end
            end
         end
         STR: begin
            w_count = 1'b1;
            if (in_data == "\"") begin w_byte_state = WS_TRAIL; w_byte_type = TY_STRING; end
            else if (in_data == "\\") w_byte_state = STR_ESC;
            else if (in_data < 8'h20) begin w_byte_err = ST_INVALID; w_count = 1'b0; end
         end
         STR_ESC: begin
            w_count = 1'b1;
            case (in_data)
               "\"", "\\", "/", "b", "f", "n", "r", "t": w_byte_state = STR;
               "u":     begin w_byte_state = STR_HEX; w_hex_cnt_n = 2'd0; end
               default: begin w_byte_err = ST_INVALID; w_count = 1'b0; end
            endcase
         end
         STR_HEX: begin
            if (w_is_hex) begin
               w_count     = 1'b1;
               w_hex_cnt_n = r_hex_cnt + 2'd1;
               if (r_hex_cnt == 2'd3) w_byte_state = STR;
            end else w_byte_err = ST_INVALID;
         end
         WS_TRAIL: if (!w_is_ws) w_byte_err = ST_NOT_SNG;
         default: ;
      endcase
      if (w_byte_err != ST_OK) w_byte_state = DRAIN;
   end

   // Final result when the current byte carries in_last.
   always_comb begin
      w_fin_status = ST_OK;
      w_fin_type   = TY_NONE;
      if (r_state == DRAIN) w_fin_status = r_err;
      else if (w_byte_err != ST_OK) w_fin_status = w_byte_err;
      else begin
         case (w_byte_state)
            WS_LEAD:                w_fin_status = ST_NO_VAL;
            STR, STR_ESC, STR_HEX:  w_fin_status = ST_MISS_Q;
            NUM: if (w_num_acc) w_fin_type = TY_NUMBER; else w_fin_status = ST_INVALID;
            WS_TRAIL:               w_fin_type = w_byte_type;
            default:                w_fin_status = ST_INVALID;
         endcase
      end
   end

   // Next-state selection around the byte and result handshakes.
   always_comb begin
      w_next_state = r_state;
      if (r_state == REPORT) begin
         if (out_ready) w_next_state = WS_LEAD;
      end else if (w_accept) begin
         w_next_state = in_last ? REPORT : w_byte_state;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) r_state <= WS_LEAD;
      else     r_state <= w_next_state;
   end

   // Scan counters, error latch and held result registers.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the async reset clears every datapath register so a partial text leaves no residue.
      if (rst) begin
         r_num_sub <= N_SIGN;  r_lit_kind <= 2'd0;  r_lit_idx <= 3'd0;
         r_hex_cnt <= 2'd0;    r_err <= ST_OK;      r_type <= TY_NONE;
         r_len <= 16'd0;       r_out_status <= ST_OK;
         r_out_type <= TY_NONE; r_out_len <= 16'd0;
      end else if (r_state == REPORT) begin
         if (out_ready) begin
            r_num_sub <= N_SIGN;  r_lit_kind <= 2'd0;  r_lit_idx <= 3'd0;
            r_hex_cnt <= 2'd0;    r_err <= ST_OK;      r_type <= TY_NONE;
            r_len <= 16'd0;       r_out_status <= ST_OK;
            r_out_type <= TY_NONE; r_out_len <= 16'd0;
         end
      end else if (w_accept) begin
         if (in_last) begin
            r_out_status <= w_fin_status;
            r_out_type   <= (w_fin_status == ST_OK) ? w_fin_type : TY_NONE;
            r_out_len    <= (w_fin_status == ST_OK) ? w_len_n : 16'd0;
         end else begin
            r_num_sub  <= w_num_sub_n;
            r_lit_kind <= w_lit_kind_n;
            r_lit_idx  <= w_lit_idx_n;
            r_hex_cnt  <= w_hex_cnt_n;
            r_type     <= w_byte_type;
            r_len      <= w_len_n;
            if (w_byte_err != ST_OK) r_err <= w_byte_err;
         end
      end
   end

   // Handshake outputs decoded from the state.
   always_comb begin
      in_ready   = (r_state != REPORT);
      out_valid  = (r_state == REPORT);
      out_status = r_out_status;
      out_type   = r_out_type;
      out_len    = r_out_len;
   end

endmodule
